fsm_decade_ctrl: RTL and testbench

Run controller for a chain of decade (mod-10) counter digits. It loads a BCD target on a start request and advances the digit chain on qualified ticks. It supports pause/resume and abort, and reports completion through a done/ack handshake. It sits between the control plane and the decade counter datapath, sequencing when the digits count and when they stop.

---
 rtl/fsm_decade_ctrl.sv | 140 ++++++++++++++
 tb/tb_fsm_decade_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_decade_ctrl.sv
// Run controller for a DIGITS-wide BCD decade counter chain: start/target load, tick advance, pause, clear, done/ack.
// Optional FSM_CTRL_AUTORELOAD_EN: terminal count pulses done, restarts from zero and keeps running.
module fsm_decade_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] target,
    input  logic                tick,
    input  logic                pause,
    input  logic                clear,
    input  logic                ack,
    output logic [4*DIGITS-1:0] cnt,
    output logic                busy,
    output logic                done,
    output logic                wrap,
    output logic                err
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   tgt, tgt_nxt, cnt_nxt, inc;
    logic           busy_nxt, done_nxt, wrap_nxt, err_nxt;
    logic           tgt_ok, all_nine;
`ifdef FSM_CTRL_AUTORELOAD_EN
    logic           term;
`endif

    // Ripple BCD increment: a digit advances only when every lower digit rolled 9->0.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign inc = bcd_inc(cnt);

    always_comb begin
        tgt_ok   = 1'b1;
        all_nine = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (target[4*k +: 4] > 4'd9) tgt_ok = 1'b0;
            if (cnt[4*k +: 4] != 4'd9)   all_nine = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef FSM_CTRL_AUTORELOAD_EN
        term      = 1'b0;
`endif
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (tgt_ok) begin
                            tgt_nxt   = target;
                            cnt_nxt   = '0;
                            state_nxt = RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        cnt_nxt  = inc;
                        wrap_nxt = all_nine;
                        // target 0 matches after the full-scale roll, giving 10^DIGITS ticks
                        if (inc == tgt) begin
`ifdef FSM_CTRL_AUTORELOAD_EN
                            cnt_nxt = '0;
                            term    = 1'b1;
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) state_nxt = RUN;
                end
                DONE: begin
                    if (ack) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
`ifdef FSM_CTRL_AUTORELOAD_EN
        done_nxt = term;
`else
        done_nxt = (state_nxt == DONE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tgt   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            wrap  <= wrap_nxt;
            err   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_fsm_decade_ctrl.sv
// Bench for fsm_decade_ctrl: directed steps then random traffic against an integer-valued reference model.
module tb_fsm_decade_ctrl;
    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int FULL   = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, tick = 1'b0, pause = 1'b0, clear = 1'b0, ack = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] cnt;
    logic         busy, done, wrap, err;

    int nvec = 0;
    int nerr = 0;

    // reference model: count kept as a plain integer
    int m_val = 0, m_tgt = 0;
    bit m_busy = 0, m_paused = 0, m_done = 0, m_dpulse = 0, m_wrap = 0, m_err = 0;

    fsm_decade_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .tick(tick),
        .pause(pause), .clear(clear), .ack(ack),
        .cnt(cnt), .busy(busy), .done(done), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int v, s;
        v = 0;
        s = 1;
        for (int k = 0; k < DIGITS; k++) begin
            v = v + int'(b[4*k +: 4]) * s;
            s = s * 10;
        end
        return v;
    endfunction

    function automatic bit legal(input logic [W-1:0] b);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (b[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        m_wrap   = 0;
        m_err    = 0;
        m_dpulse = 0;
        if (clear) begin
            m_busy = 0; m_paused = 0; m_done = 0; m_val = 0;
        end else if (m_done) begin
            if (ack) m_done = 0;
        end else if (!m_busy) begin
            if (start) begin
                if (legal(target)) begin
                    m_tgt = from_bcd(target); m_val = 0; m_busy = 1; m_paused = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_paused) begin
            if (!pause) m_paused = 0;
        end else if (pause) begin
            m_paused = 1;
        end else if (tick) begin
            m_val  = (m_val + 1) % FULL;
            m_wrap = (m_val == 0);
            if (m_val == m_tgt) begin
`ifdef FSM_CTRL_AUTORELOAD_EN
                m_val = 0; m_dpulse = 1;
`else
                m_busy = 0; m_done = 1;
`endif
            end
        end
    endtask

    // one clock: model consumes the same inputs the DUT sees, outputs compared 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("cnt",  cnt,  to_bcd(m_val));
        chk("busy", busy, m_busy);
        chk("done", done, m_done | m_dpulse);
        chk("wrap", wrap, m_wrap);
        chk("err",  err,  m_err);
    endtask

    initial begin
        int  n, pcnt;
        bit  carry_seen;
        logic [W-1:0] prev;

        #12;
        chk("rst_cnt",  cnt,  0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err",  err,  0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();

`ifndef FSM_CTRL_AUTORELOAD_EN
        // target 12, tick held high
        target = 8'h12; start = 1; tick = 1;
        step();
        start = 0;
        chk("t12_start_busy", busy, 1);
        n = 0;
        while (!done && n < 50) begin step(); n++; end
        chk("t12_ticks", n, 12);
        chk("t12_cnt", cnt, 8'h12);
        chk("t12_busy", busy, 0);
        ack = 1; step(); ack = 0;
        chk("t12_ack_done", done, 0);
        chk("t12_ack_cnt_hold", cnt, 8'h12);

        // target 25 with a 3-cycle pause at 09, carry 09->10
        target = 8'h25; start = 1; step(); start = 0;
        n = 0; pcnt = 0; carry_seen = 0;
        while (!done && n < 100) begin
            if (cnt == 8'h09 && pcnt < 3) begin pause = 1; pcnt++; end
            else pause = 0;
            prev = cnt;
            step();
            if (prev == 8'h09 && cnt == 8'h10) carry_seen = 1;
            n++;
        end
        pause = 0;
        chk("t25_carry", carry_seen, 1);
        chk("t25_cnt", cnt, 8'h25);
        chk("t25_done", done, 1);
        ack = 1; step(); ack = 0;

        // target 00 = full range, wrap and done on the same edge
        target = 8'h00; start = 1; step(); start = 0;
        n = 0;
        while (!done && n < 150) begin step(); n++; end
        chk("t00_ticks", n, 100);
        chk("t00_wrap", wrap, 1);
        chk("t00_cnt", cnt, 0);
        step();
        chk("t00_wrap_1cyc", wrap, 0);
        ack = 1; step(); ack = 0;

        // illegal target
        target = 8'h1A; start = 1; step(); start = 0;
        chk("t1a_err", err, 1);
        chk("t1a_busy", busy, 0);
        chk("t1a_cnt", cnt, 0);
        step();
        chk("t1a_err_1cyc", err, 0);

        // clear beats start mid-run
        target = 8'h50; start = 1; step(); start = 0;
        n = 0;
        while (cnt != 8'h07 && n < 30) begin step(); n++; end
        chk("clr_reach7", cnt, 8'h07);
        clear = 1; start = 1; step(); clear = 0; start = 0;
        chk("clr_cnt", cnt, 0);
        chk("clr_busy", busy, 0);
        step();
        chk("clr_start_ignored", busy, 0);
`else
        // autoreload: target 03, done every 3rd tick, ack ignored
        target = 8'h03; start = 1; tick = 1; ack = 1;
        step();
        start = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("ar_cnt", cnt, i % 3);
            chk("ar_done", done, (i % 3) == 0);
            chk("ar_busy", busy, 1);
        end
        ack = 0;
        clear = 1; step(); clear = 0;
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            clear  = ($urandom_range(63) == 0);
            start  = ($urandom_range(7) == 0);
            ack    = ($urandom_range(3) == 0);
            pause  = ($urandom_range(5) == 0);
            tick   = ($urandom_range(7) != 0);
            for (int k = 0; k < DIGITS; k++)
                target[4*k +: 4] = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 10))
                                                            : 4'($urandom_range(9));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
